bram_dump_seq: RTL

Sequencer that streams a contiguous address range of the 8x2048 single-port block RAM out through the byte UART transmitter, one byte per UART frame. It drives the BRAM address and enable, waits for the BRAM read latency, latches the read data, and completes a req/busy handshake with the UART TX. It sits between the top-level control (start/abort, LEDs) and the existing BRAM and UART instances, and replaces ad-hoc dump FSMs in top modules.

---
 rtl/bram_dump_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bram_dump_seq.sv
// Streams a contiguous (wrapping) BRAM address range out through a byte UART,
// one byte per frame, with a req/busy handshake and an ack timeout.
module bram_dump_seq #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 2,
   parameter int ACK_TO = 1023
) (
   input  logic              CLK_50M,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   input  logic [DATA_W-1:0] bram_dout,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_req,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   byte_cnt,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_REQ   = 3'd4,
      S_DRAIN = 3'd5,
      S_FIN   = 3'd6
   } state_t;

   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [9:0]      TO_MAX  = 10'(ACK_TO);
   localparam logic [1:0]      LAT_END = 2'(RD_LAT - 2);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     offset_q, offset_d;
   logic [1:0]          lat_q, lat_d;
   logic [9:0]          to_q, to_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                en_q, en_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                err_q, err_d;

   always_ff @(posedge CLK_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         offset_q <= '0;
         lat_q    <= '0;
         to_q     <= '0;
         addr_q   <= '0;
         en_q     <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         lat_q    <= lat_d;
         to_q     <= to_d;
         addr_q   <= addr_d;
         en_q     <= en_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      offset_d = offset_q;
      lat_d    = lat_q;
      to_d     = to_q;
      addr_d   = addr_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d   = base_addr;
               len_d    = (length == '0) ? LEN_MAX : length;
               offset_d = '0;
               cnt_d    = '0;
               err_d    = 1'b0;
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (abort) begin
               state_d = S_FIN;
            end else begin
               // Truncation to ADDR_W bits gives the 2047 -> 0 wrap.
               addr_d  = base_q + offset_q[ADDR_W-1:0];
               lat_d   = '0;
               state_d = (RD_LAT == 1) ? S_LOAD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort)                state_d = S_FIN;
            else if (lat_q == LAT_END) state_d = S_LOAD;
            else                      lat_d = lat_q + 2'd1;
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_FIN;
            end else begin
               data_d  = bram_dout;
               to_d    = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Abort is not checked here so a started frame is never truncated.
            if (tx_busy) begin
               cnt_d   = cnt_q + ONE_L;
               state_d = S_DRAIN;
            end else if (to_q == TO_MAX) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end else begin
               to_d = to_q + 10'd1;
            end
         end
         S_DRAIN: begin
            if (!tx_busy) begin
               if (abort || offset_q == len_q - ONE_L) begin
                  state_d = S_FIN;
               end else begin
                  offset_d = offset_q + ONE_L;
                  state_d  = S_ADDR;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      en_d = (state_d == S_WAIT) || (state_d == S_LOAD);
   end

   assign bram_addr = addr_q;
   assign bram_en   = en_q;
   assign tx_data   = data_q;
   assign tx_req    = (state_q == S_REQ);
   assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done      = (state_q == S_FIN);
   assign err       = err_q;
   assign byte_cnt  = cnt_q;
   assign state     = state_q;

endmodule
